// File: rtl/ram_cycle_ctrl.sv
// 68000 bus-cycle sequencer for on-board fast SRAM: synchronised strobes, registered SRAM enables, DTACK after wait states.
// Optional AUTOCONFIG_ACK_EN: adds config_sel and acknowledges autoconfig-space cycles directly with zero wait states.
module ram_cycle_ctrl #(
    parameter int READ_WS  = 1,
    parameter int WRITE_WS = 0,
    parameter int CNT_W    = 3
) (
    input  logic CLK,
    input  logic _RST,
    input  logic _AS,
    input  logic _UDS,
    input  logic _LDS,
    input  logic RW,
    input  logic ramce,
`ifdef AUTOCONFIG_ACK_EN
    input  logic config_sel,
`endif
    output logic _RAMCE,
    output logic _RAMOE,
    output logic _RAMWEU,
    output logic _RAMWEL,
    output logic DTACK,
    output logic busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] ACK    = 3'd3;
    localparam logic [2:0] TERM   = 3'd4;

    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WS);
    localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_WS);
    localparam logic [2:0] READ_NEXT  = (READ_WS > 0)  ? WAIT : ACK;
    localparam logic [2:0] WRITE_NEXT = (WRITE_WS > 0) ? WAIT : ACK;

    // Strobe pins in order {_AS, _UDS, _LDS}; sync flops idle at 1 (negated).
    logic [2:0] strobe_pins;
    logic [2:0] strobe_s;
    assign strobe_pins = {_AS, _UDS, _LDS};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [1:0] sync_reg;
            always_ff @(posedge CLK or negedge _RST) begin
                if (!_RST) begin
                    sync_reg <= 2'b11;
                end else begin
                    sync_reg <= {sync_reg[0], strobe_pins[gi]};
                end
            end
            assign strobe_s[gi] = ~sync_reg[1];
        end
    endgenerate

    logic as_s, uds_s, lds_s;
    assign as_s  = strobe_s[2];
    assign uds_s = strobe_s[1];
    assign lds_s = strobe_s[0];

    logic [2:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             rw_reg;
    logic             ce_n_reg, oe_n_reg, weu_n_reg, wel_n_reg, dtack_reg;

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rw_reg    <= 1'b1;
            ce_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            weu_n_reg <= 1'b1;
            wel_n_reg <= 1'b1;
            dtack_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (as_s && ramce) begin
                        state_reg <= DECODE;
                        rw_reg    <= RW;
                        if (RW) begin
                            ce_n_reg <= 1'b0;
                            oe_n_reg <= 1'b0;
                        end
                    end
`ifdef AUTOCONFIG_ACK_EN
                    else if (as_s && config_sel) begin
                        state_reg <= ACK;
                    end
`endif
                end
                DECODE: begin
                    if (!as_s) begin
                        state_reg <= TERM;
                        ce_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        weu_n_reg <= 1'b1;
                        wel_n_reg <= 1'b1;
                        dtack_reg <= 1'b0;
                    end else if (rw_reg) begin
                        cnt_reg   <= READ_LOAD;
                        state_reg <= READ_NEXT;
                    end else if (uds_s || lds_s) begin
                        ce_n_reg  <= 1'b0;
                        weu_n_reg <= !uds_s;
                        wel_n_reg <= !lds_s;
                        cnt_reg   <= WRITE_LOAD;
                        state_reg <= WRITE_NEXT;
                    end
                end
                WAIT: begin
                    if (!as_s) begin
                        state_reg <= TERM;
                        ce_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        weu_n_reg <= 1'b1;
                        wel_n_reg <= 1'b1;
                        dtack_reg <= 1'b0;
                    end else begin
                        // Leaving on count 1 makes the WAIT dwell exactly the loaded count.
                        if (cnt_reg <= CNT_W'(1)) begin
                            state_reg <= ACK;
                        end
                        cnt_reg <= (cnt_reg != '0) ? cnt_reg - CNT_W'(1) : '0;
                    end
                end
                ACK: begin
                    if (!as_s) begin
                        state_reg <= TERM;
                        ce_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        weu_n_reg <= 1'b1;
                        wel_n_reg <= 1'b1;
                        dtack_reg <= 1'b0;
                    end else begin
                        dtack_reg <= 1'b1;
                    end
                end
                TERM: begin
                    state_reg <= IDLE;
                    ce_n_reg  <= 1'b1;
                    oe_n_reg  <= 1'b1;
                    weu_n_reg <= 1'b1;
                    wel_n_reg <= 1'b1;
                    dtack_reg <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign _RAMCE  = ce_n_reg;
    assign _RAMOE  = oe_n_reg;
    assign _RAMWEU = weu_n_reg;
    assign _RAMWEL = wel_n_reg;
    assign DTACK   = dtack_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_ram_cycle_ctrl.sv
// Directed bench for ram_cycle_ctrl: reads, word/byte writes, abort, async reset, autoconfig ack.
module tb_ram_cycle_ctrl;

    logic clk = 1'b0;
    logic rst_n, as_n, uds_n, lds_n, rw, ramce, config_sel;
    logic ce_n, oe_n, weu_n, wel_n, dtack, busy;
    logic ce3_n, oe3_n, weu3_n, wel3_n, dtack3, busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_cycle_ctrl dut (
        .CLK(clk), ._RST(rst_n), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n), .RW(rw), .ramce(ramce),
`ifdef AUTOCONFIG_ACK_EN
        .config_sel(config_sel),
`endif
        ._RAMCE(ce_n), ._RAMOE(oe_n), ._RAMWEU(weu_n), ._RAMWEL(wel_n), .DTACK(dtack), .busy(busy)
    );

    ram_cycle_ctrl #(.READ_WS(3)) dut_ws3 (
        .CLK(clk), ._RST(rst_n), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n), .RW(rw), .ramce(ramce),
`ifdef AUTOCONFIG_ACK_EN
        .config_sel(config_sel),
`endif
        ._RAMCE(ce3_n), ._RAMOE(oe3_n), ._RAMWEU(weu3_n), ._RAMWEL(wel3_n), .DTACK(dtack3), .busy(busy3)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_release();
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; ramce = 1'b0; config_sel = 1'b0; rw = 1'b1;
    endtask

    logic exp_cfg_ack;

    initial begin
`ifdef AUTOCONFIG_ACK_EN
        exp_cfg_ack = 1'b1;
`else
        exp_cfg_ack = 1'b0;
`endif
        rst_n = 1'b0;
        bus_release();
        tick(2);
        check("rst_ce", ce_n, 1'b1);
        check("rst_oe", oe_n, 1'b1);
        check("rst_weu", weu_n, 1'b1);
        check("rst_wel", wel_n, 1'b1);
        check("rst_dtack", dtack, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick(3);

        // Read, READ_WS=1: enables at 3rd edge after pin fall, DTACK 3 edges after that.
        rw = 1'b1; ramce = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
        tick(2);
        check("rd_ce_early", ce_n, 1'b1);
        tick(1);
        check("rd_ce", ce_n, 1'b0);
        check("rd_oe", oe_n, 1'b0);
        check("rd_busy", busy, 1'b1);
        check("rd_weu", weu_n, 1'b1);
        tick(2);
        check("rd_dtack_early", dtack, 1'b0);
        tick(1);
        check("rd_dtack", dtack, 1'b1);
        bus_release();
        tick(2);
        check("rd_hold_dtack", dtack, 1'b1);
        tick(1);
        check("rd_rel_ce", ce_n, 1'b1);
        check("rd_rel_oe", oe_n, 1'b1);
        check("rd_rel_dtack", dtack, 1'b0);
        check("rd_term_busy", busy, 1'b1);
        tick(1);
        check("rd_idle_busy", busy, 1'b0);
        $display("txn read ws1 done checks=%0d errors=%0d", checks, errors);
        tick(6);

        // Word write, WRITE_WS=0: strobes follow _AS by one clock.
        rw = 1'b0; ramce = 1'b1; as_n = 1'b0;
        tick(1);
        uds_n = 1'b0; lds_n = 1'b0;
        tick(2);
        check("ww_ce_decode", ce_n, 1'b1);
        check("ww_busy", busy, 1'b1);
        tick(1);
        check("ww_ce", ce_n, 1'b0);
        check("ww_weu", weu_n, 1'b0);
        check("ww_wel", wel_n, 1'b0);
        check("ww_oe", oe_n, 1'b1);
        check("ww_dtack_early", dtack, 1'b0);
        tick(1);
        check("ww_dtack", dtack, 1'b1);
        check("ww_oe_ack", oe_n, 1'b1);
        bus_release();
        tick(3);
        check("ww_rel_weu", weu_n, 1'b1);
        check("ww_rel_dtack", dtack, 1'b0);
        $display("txn word write done checks=%0d errors=%0d", checks, errors);
        tick(6);

        // Byte write on D7..0 only.
        rw = 1'b0; ramce = 1'b1; as_n = 1'b0;
        tick(1);
        lds_n = 1'b0;
        tick(3);
        check("bw_ce", ce_n, 1'b0);
        check("bw_wel", wel_n, 1'b0);
        check("bw_weu", weu_n, 1'b1);
        tick(1);
        check("bw_dtack", dtack, 1'b1);
        check("bw_weu_ack", weu_n, 1'b1);
        bus_release();
        tick(3);
        check("bw_rel_wel", wel_n, 1'b1);
        $display("txn byte write done checks=%0d errors=%0d", checks, errors);
        tick(6);

        // Abort on the READ_WS=3 instance: _AS negated while it sits in WAIT.
        rw = 1'b1; ramce = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
        tick(3);
        check("ab_ce", ce3_n, 1'b0);
        tick(1);
        bus_release();
        tick(2);
        check("ab_busy_wait", busy3, 1'b1);
        check("ab_dtack_wait", dtack3, 1'b0);
        tick(1);
        check("ab_term_busy", busy3, 1'b1);
        check("ab_term_ce", ce3_n, 1'b1);
        check("ab_term_oe", oe3_n, 1'b1);
        check("ab_term_dtack", dtack3, 1'b0);
        tick(1);
        check("ab_idle_busy", busy3, 1'b0);
        check("ab_idle_dtack", dtack3, 1'b0);
        $display("txn abort ws3 done checks=%0d errors=%0d", checks, errors);
        tick(8);

        // Reset pulse while DTACK is high, between clock edges.
        rw = 1'b1; ramce = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
        tick(6);
        check("mr_dtack_pre", dtack, 1'b1);
        rst_n = 1'b0;
        #2;
        check("mr_dtack", dtack, 1'b0);
        check("mr_ce", ce_n, 1'b1);
        check("mr_oe", oe_n, 1'b1);
        check("mr_busy", busy, 1'b0);
        bus_release();
        #2;
        rst_n = 1'b1;
        tick(4);
        rw = 1'b1; ramce = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
        tick(3);
        check("mr2_ce", ce_n, 1'b0);
        tick(3);
        check("mr2_dtack", dtack, 1'b1);
        bus_release();
        tick(4);
        check("mr2_idle", busy, 1'b0);
        $display("txn reset mid-ack done checks=%0d errors=%0d", checks, errors);
        tick(6);

        // Autoconfig-space cycle: ramce low, config_sel high.
        rw = 1'b1; ramce = 1'b0; config_sel = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
        tick(3);
        check("cfg_dtack_early", dtack, 1'b0);
        tick(1);
        check("cfg_dtack", dtack, exp_cfg_ack);
        check("cfg_ce", ce_n, 1'b1);
        check("cfg_oe", oe_n, 1'b1);
        check("cfg_busy", busy, exp_cfg_ack);
        bus_release();
        tick(4);
        check("cfg_rel_dtack", dtack, 1'b0);
        check("cfg_rel_busy", busy, 1'b0);
        $display("txn autoconfig done checks=%0d errors=%0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
